// File: rtl/sram_arbiter.sv
// Two-master (fetch I, data D) to one-slave SRAM-like bus arbiter, one outstanding transaction.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed priority D over I.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  req_t   lat_q, lat_d;
  req_t   i_fields, d_fields;
  logic   pick_d;
  logic   addr_ok_c;
  logic   data_ok_c;

  assign i_fields = {i_wr, i_size, i_addr, i_wdata};
  assign d_fields = {d_wr, d_size, d_addr, d_wdata};

  // Arbitration: 1 selects D, 0 selects I; a lone requester always wins.
  always_comb begin
    pick_d = d_req;
`ifdef SRAM_ARB_RR_EN
    if (d_req && i_req) begin
      pick_d = ~owner_q;
    end
`endif
  end

  // Next-state: grant only from IDLE, request fields frozen until the next grant.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req || i_req) begin
          owner_d = pick_d;
          lat_d   = pick_d ? d_fields : i_fields;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_addr_ok) begin
          state_d = s_data_ok ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
    end
  end

  // Slave handshakes are forwarded to the owner in the same cycle.
  assign addr_ok_c = (state_q == ST_REQ) && s_addr_ok;
  assign data_ok_c = ((state_q == ST_REQ) && s_addr_ok && s_data_ok) ||
                     ((state_q == ST_WAIT) && s_data_ok);

  assign i_addr_ok = addr_ok_c & ~owner_q;
  assign i_data_ok = data_ok_c & ~owner_q;
  assign d_addr_ok = addr_ok_c & owner_q;
  assign d_data_ok = data_ok_c & owner_q;
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;

  assign s_req   = (state_q == ST_REQ);
  assign s_wr    = lat_q.wr;
  assign s_size  = lat_q.size;
  assign s_addr  = lat_q.addr;
  assign s_wdata = lat_q.wdata;
  assign busy    = (state_q != ST_IDLE);
  assign owner   = owner_q;

endmodule
